uvmt_apb_st_rst_sequencer: RTL and testbench
============================================

# uvmt_apb_st_rst_sequencer

Reset and clock-enable sequencer for the APB self-test bench. It takes the raw bench reset and software reset requests and produces a properly ordered reset, clock-enable and ready sequence for the DUT and agents:
- hold reset with the clock gated,
- enable the clock,
- release reset,
- settle, then signal ready.

It sits between the bench clock/reset generator and every clocked consumer in the self-test bench.

## Interface
Parameters:
- CNT_W, 8, width of the internal counter and of `hold_cycles`.
- ASSERT_CYCLES, 8, reset hold length H after power-on reset. Range 1..2^CNT_W-1.
- CLK_EN_LEAD, 2, cycles L between `clk_en` rising and reset release. 0 is legal.
- SETTLE_CYCLES, 4, cycles S between reset release and `ready`. 0 is legal.
- WDOG_CYCLES, 255, watchdog timeout. Present only with the watchdog macro.

Ports:
- clk  in  1  bench clock.
- reset_n  in  1  asynchronous, active-low reset.
- sw_rst_req  in  1  software reset request, level sampled each cycle.
- hold_cycles  in  CNT_W  hold length for a software reset. 0 selects ASSERT_CYCLES.
- sw_rst_ack  out  1  one-cycle pulse: request accepted.
- rst_out_n  out  1  sequenced active-low reset.
- rst_out  out  1  always the inverse of `rst_out_n`.
- clk_en  out  1  clock enable / gate for downstream logic.
- ready  out  1  sequence complete, system running.
- kick  in  1  watchdog refresh. Watchdog macro only.
- wdog_fired  out  1  sticky watchdog-reset flag. Watchdog macro only.

## Operation
- Synchronizer: `reset_n` goes through a 2-flop synchronizer. Assertion is asynchronous; deassertion is synchronous. While the synchronized reset is low, the FSM is forced to HOLD with the counter loaded for H = ASSERT_CYCLES.
- Reset values (all asynchronous): `rst_out_n`=0, `rst_out`=1, `clk_en`=0, `ready`=0, `sw_rst_ack`=0, `wdog_fired`=0.
- FSM states, in order HOLD -> LEAD -> SETTLE -> RUN:
  - HOLD: `rst_out_n`=0, `clk_en`=0. Stays exactly H cycles, then goes to LEAD. If L=0, it skips LEAD and goes straight to SETTLE.
  - LEAD: `clk_en`=1, `rst_out_n`=0. Stays L cycles.
  - SETTLE: `clk_en`=1, `rst_out_n`=1. Stays S cycles. If S=0, it is skipped.
  - RUN: all three outputs 1. Holds until a software reset, a watchdog reset or `reset_n` assertion.
- Counter: a single down-counter is loaded with the state length minus 1 on state entry. The state exits on the cycle the counter reads 0.
- Software reset:
  - `sw_rst_req` is honoured only in RUN. It is ignored, with no ack and no queuing, in all other states.
  - On acceptance: `sw_rst_ack` pulses for 1 cycle, and the FSM enters HOLD with H = `hold_cycles` if nonzero, otherwise ASSERT_CYCLES.
  - `hold_cycles` is sampled only on the accepting edge.
  - `sw_rst_req` held high causes one reset per return to RUN.
- Power-on always uses ASSERT_CYCLES. `hold_cycles` is ignored.
- `reset_n` asserted mid-sequence: outputs go to reset values immediately and the sequence restarts from power-on.
- All outputs are registered; none is combinational from an input.

## Timing
Edge numbering: edge 0 is the first rising edge with `reset_n`=1.

Power-on sequence:
- Synchronized reset goes high after edge 1.
- `clk_en` rises after edge 1+H.
- `rst_out_n` rises after edge 1+H+L.
- `ready` rises after edge 1+H+L+S.
- With defaults: `clk_en` after edge 9, `rst_out_n` after edge 11, `ready` after edge 15.

Software reset, with `sw_rst_req` sampled at edge n in RUN:
- After edge n: `sw_rst_ack`=1 for one cycle, and `ready`, `clk_en`, `rst_out_n` all go 0.
- `clk_en` rises after edge n+H.
- `rst_out_n` rises after edge n+H+L.
- `ready` rises after edge n+H+L+S.

## Configuration
Macro: `UVMT_APB_ST_RST_SEQ_WDOG_EN`.

Defined:
- Adds `kick`, `wdog_fired` and WDOG_CYCLES.
- In RUN, a counter increments each cycle. It clears on `kick` and on leaving RUN.
- When the counter reaches WDOG_CYCLES without a kick, the FSM behaves as a software reset with H=ASSERT_CYCLES, except that no ack is issued. `wdog_fired` is set and is cleared only by `reset_n`.
- Priority on the same edge:
  - `kick` beats expiry: no reset.
  - `sw_rst_req` beats expiry: ack issued, `wdog_fired` unchanged.

Undefined: the ports, parameter and logic are absent, and behaviour is otherwise identical.

## Test plan
- Power-on, defaults: release `reset_n` before edge 0 -> `clk_en` 1 after edge 9, `rst_out_n` 1 after edge 11, `ready` 1 after edge 15, `rst_out` == !`rst_out_n` every cycle.
- Software reset with `hold_cycles`=3, `sw_rst_req` at edge 40 in RUN -> `sw_rst_ack` high for exactly one cycle; `clk_en` rises after edge 43, `rst_out_n` after edge 45, `ready` after edge 49.
- Requests outside RUN: `sw_rst_req` pulsed during HOLD, LEAD and SETTLE -> no ack, sequence timing unchanged. Also `hold_cycles`=0 in RUN -> H=8.
- Mid-sequence reset: `reset_n` driven low in LEAD -> all outputs at reset values in the same timestep; full power-on timing repeats after re-release.
- Parameters L=0, S=0: `clk_en`, `rst_out_n` and `ready` all rise together after edge 1+H.
- Watchdog, macro defined with WDOG_CYCLES=20:
  - no `kick` for 20 RUN cycles -> reset sequence starts and `wdog_fired`=1;
  - `kick` on the expiry edge -> no reset;
  - `sw_rst_req` on the expiry edge -> ack issued, `wdog_fired`=0.

Source files
------------

// File: rtl/uvmt_apb_st_rst_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uvmt_apb_st_rst_sequencer                                  |
// | Description : Orders reset, clock-enable and ready for the APB self-test |
// |               bench: HOLD -> LEAD -> SETTLE -> RUN, with software reset  |
// |               requests and an optional watchdog enabled by the macro     |
// |               UVMT_APB_ST_RST_SEQ_WDOG_EN.                               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uvmt_apb_st_rst_sequencer #(
  parameter int CNT_W         = 8,
  parameter int ASSERT_CYCLES = 8,
  parameter int CLK_EN_LEAD   = 2,
`ifdef UVMT_APB_ST_RST_SEQ_WDOG_EN
  parameter int SETTLE_CYCLES = 4,
  parameter int WDOG_CYCLES   = 255
`else
  parameter int SETTLE_CYCLES = 4
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sw_rst_req,
  input  logic [CNT_W-1:0] hold_cycles,
`ifdef UVMT_APB_ST_RST_SEQ_WDOG_EN
  input  logic             kick,
  output logic             wdog_fired,
`endif
  output logic             sw_rst_ack,
  output logic             rst_out_n,
  output logic             rst_out,
  output logic             clk_en,
  output logic             ready
);

  typedef enum logic [1:0] {
    S_HOLD   = 2'd0,
    S_LEAD   = 2'd1,
    S_SETTLE = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  // Counter reload values are "length minus one"; zero-length states are skipped.
  localparam logic [CNT_W-1:0] c_hold_m1   = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_lead_m1   = CNT_W'((CLK_EN_LEAD > 0) ? CLK_EN_LEAD - 1 : 0);
  localparam logic [CNT_W-1:0] c_settle_m1 = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam state_t c_after_lead = (SETTLE_CYCLES > 0) ? S_SETTLE : S_RUN;
  localparam state_t c_after_hold = (CLK_EN_LEAD > 0) ? S_LEAD : c_after_lead;
  localparam logic [CNT_W-1:0] c_after_hold_cnt = (CLK_EN_LEAD > 0) ? c_lead_m1 : c_settle_m1;

  logic [1:0]       r_sync;
  logic             r_sync_n;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  state_t           w_nxt_state;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic             w_ack;
  logic             w_wdog_expire;
  logic             w_fire;

  assign r_sync_n = r_sync[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], 1'b1};
    end
  end

`ifdef UVMT_APB_ST_RST_SEQ_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] c_wdog_last = WD_W'(WDOG_CYCLES - 1);

  logic [WD_W-1:0] r_wdog;

  assign w_wdog_expire = (r_state == S_RUN) && !kick && (r_wdog == c_wdog_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wdog     <= '0;
      wdog_fired <= 1'b0;
    end else begin
      if (r_sync_n && (r_state == S_RUN) && (w_nxt_state == S_RUN) && !kick) begin
        r_wdog <= r_wdog + WD_W'(1);
      end else begin
        r_wdog <= '0;
      end
      if (r_sync_n && w_fire) begin
        wdog_fired <= 1'b1;
      end
    end
  end
`else
  assign w_wdog_expire = 1'b0;
`endif

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt - CNT_W'(1);
    w_ack       = 1'b0;
    w_fire      = 1'b0;
    case (r_state)
      S_HOLD: begin
        if (r_cnt == '0) begin
          w_nxt_state = c_after_hold;
          w_nxt_cnt   = c_after_hold_cnt;
        end
      end
      S_LEAD: begin
        if (r_cnt == '0) begin
          w_nxt_state = c_after_lead;
          w_nxt_cnt   = c_settle_m1;
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) begin
          w_nxt_state = S_RUN;
          w_nxt_cnt   = '0;
        end
      end
      S_RUN: begin
        w_nxt_cnt = '0;
        // A software request outranks watchdog expiry on the same edge.
        if (sw_rst_req) begin
          w_nxt_state = S_HOLD;
          w_nxt_cnt   = (hold_cycles != '0) ? hold_cycles - CNT_W'(1) : c_hold_m1;
          w_ack       = 1'b1;
        end else if (w_wdog_expire) begin
          w_nxt_state = S_HOLD;
          w_nxt_cnt   = c_hold_m1;
          w_fire      = 1'b1;
        end
      end
      default: begin
        w_nxt_state = S_HOLD;
        w_nxt_cnt   = c_hold_m1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_HOLD;
      r_cnt      <= c_hold_m1;
      rst_out_n  <= 1'b0;
      rst_out    <= 1'b1;
      clk_en     <= 1'b0;
      ready      <= 1'b0;
      sw_rst_ack <= 1'b0;
    end else if (!r_sync_n) begin
      r_state    <= S_HOLD;
      r_cnt      <= c_hold_m1;
      rst_out_n  <= 1'b0;
      rst_out    <= 1'b1;
      clk_en     <= 1'b0;
      ready      <= 1'b0;
      sw_rst_ack <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_cnt      <= w_nxt_cnt;
      rst_out_n  <= (w_nxt_state == S_SETTLE) || (w_nxt_state == S_RUN);
      rst_out    <= !((w_nxt_state == S_SETTLE) || (w_nxt_state == S_RUN));
      clk_en     <= (w_nxt_state != S_HOLD);
      ready      <= (w_nxt_state == S_RUN);
      sw_rst_ack <= w_ack;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uvmt_apb_st_rst_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uvmt_apb_st_rst_sequencer                               |
// | Description : Directed self-checking bench for the reset sequencer.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_uvmt_apb_st_rst_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic [7:0] hold_cycles = 8'd0;
  logic       kick = 1'b1;
  logic       req0 = 1'b0;
  logic [7:0] hold0 = 8'd0;

  logic sw_rst_ack, rst_out_n, rst_out, clk_en, ready;
  logic ack0, rstn0, rst0, clken0, ready0;
  logic wdog_fired, wdog_fired0;

  int n_cmp = 0;
  int n_bad = 0;
  int cur_edge = 0;

  always #5 clk = ~clk;

  uvmt_apb_st_rst_sequencer #(
`ifdef UVMT_APB_ST_RST_SEQ_WDOG_EN
    .WDOG_CYCLES(20),
`endif
    .CNT_W(8)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sw_rst_req (sw_rst_req),
    .hold_cycles(hold_cycles),
`ifdef UVMT_APB_ST_RST_SEQ_WDOG_EN
    .kick       (kick),
    .wdog_fired (wdog_fired),
`endif
    .sw_rst_ack (sw_rst_ack),
    .rst_out_n  (rst_out_n),
    .rst_out    (rst_out),
    .clk_en     (clk_en),
    .ready      (ready)
  );

  uvmt_apb_st_rst_sequencer #(
    .CNT_W        (8),
    .ASSERT_CYCLES(5),
    .CLK_EN_LEAD  (0),
    .SETTLE_CYCLES(0)
  ) u_dut_l0s0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .sw_rst_req (req0),
    .hold_cycles(hold0),
`ifdef UVMT_APB_ST_RST_SEQ_WDOG_EN
    .kick       (kick),
    .wdog_fired (wdog_fired0),
`endif
    .sw_rst_ack (ack0),
    .rst_out_n  (rstn0),
    .rst_out    (rst0),
    .clk_en     (clken0),
    .ready      (ready0)
  );

`ifndef UVMT_APB_ST_RST_SEQ_WDOG_EN
  assign wdog_fired  = 1'b0;
  assign wdog_fired0 = 1'b0;
`endif

  // Observed vector: {ready, rst_out_n, clk_en, rst_out, sw_rst_ack}
  function automatic logic [4:0] obs();
    return {ready, rst_out_n, clk_en, rst_out, sw_rst_ack};
  endfunction

  task automatic adv(input int e);
    while (cur_edge < e) begin
      @(posedge clk);
      cur_edge++;
    end
    #1;
  endtask

  // Leaves the bench 1 ns after edge 0 (first edge with reset_n high).
  task automatic power_up();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    cur_edge = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== 5'b00010) begin
      n_bad++;
      $display("FAIL reset_async got=%b exp=%b", obs(), 5'b00010);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (obs() !== 5'b00010) begin
      n_bad++;
      $display("FAIL reset_held got=%b exp=%b", obs(), 5'b00010);
    end
  endtask

  // With poke set, requests land in HOLD (4), LEAD (10) and SETTLE (13).
  task automatic test_power_on(input bit poke);
    logic [4:0] exp;
    power_up();
    for (int e = 0; e <= 16; e++) begin
      sw_rst_req = poke && (e == 4 || e == 10 || e == 13);
      adv(e);
      exp = {e >= 15, e >= 11, e >= 9, !(e >= 11), 1'b0};
      n_cmp++;
      if (obs() !== exp) begin
        n_bad++;
        $display("FAIL power_on poke=%0d edge=%0d got=%b exp=%b", poke, e, obs(), exp);
      end
    end
    sw_rst_req = 1'b0;
  endtask

  task automatic test_sw_reset();
    logic [4:0] exp;
    adv(39);
    hold_cycles = 8'd3;
    sw_rst_req  = 1'b1;
    for (int e = 40; e <= 50; e++) begin
      adv(e);
      sw_rst_req  = 1'b0;
      hold_cycles = 8'd9;
      exp = {e >= 49, e >= 45, e >= 43, !(e >= 45), e == 40};
      n_cmp++;
      if (obs() !== exp) begin
        n_bad++;
        $display("FAIL sw_reset edge=%0d got=%b exp=%b", e, obs(), exp);
      end
    end
  endtask

  task automatic test_hold_zero();
    logic [4:0] exp;
    adv(59);
    hold_cycles = 8'd0;
    sw_rst_req  = 1'b1;
    for (int e = 60; e <= 75; e++) begin
      adv(e);
      sw_rst_req = 1'b0;
      exp = {e >= 74, e >= 70, e >= 68, !(e >= 70), e == 60};
      n_cmp++;
      if (obs() !== exp) begin
        n_bad++;
        $display("FAIL hold_zero edge=%0d got=%b exp=%b", e, obs(), exp);
      end
    end
  endtask

  task automatic test_req_held();
    logic [4:0] exp;
    logic       rn;
    adv(79);
    hold_cycles = 8'd2;
    sw_rst_req  = 1'b1;
    for (int e = 80; e <= 92; e++) begin
      adv(e);
      rn  = (e >= 84) && (e < 89);
      exp = {e == 88, rn, ((e >= 82) && (e < 89)) || (e >= 91), !rn, (e == 80) || (e == 89)};
      n_cmp++;
      if (obs() !== exp) begin
        n_bad++;
        $display("FAIL req_held edge=%0d got=%b exp=%b", e, obs(), exp);
      end
    end
    sw_rst_req = 1'b0;
  endtask

  task automatic test_mid_reset();
    power_up();
    adv(10);
    n_cmp++;
    if (obs() !== 5'b00110) begin
      n_bad++;
      $display("FAIL mid_lead got=%b exp=%b", obs(), 5'b00110);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== 5'b00010) begin
      n_bad++;
      $display("FAIL mid_async got=%b exp=%b", obs(), 5'b00010);
    end
    test_power_on(1'b0);
  endtask

  task automatic test_l0_s0();
    logic [4:0] exp;
    logic [4:0] got;
    power_up();
    for (int e = 0; e <= 8; e++) begin
      adv(e);
      got = {ready0, rstn0, clken0, rst0, ack0};
      exp = {e >= 6, e >= 6, e >= 6, !(e >= 6), 1'b0};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL l0_s0 edge=%0d got=%b exp=%b", e, got, exp);
      end
    end
  endtask

`ifdef UVMT_APB_ST_RST_SEQ_WDOG_EN
  task automatic test_watchdog();
    power_up();
    kick = 1'b0;
    adv(34);
    n_cmp++;
    if ({obs(), wdog_fired} !== 6'b111000) begin
      n_bad++;
      $display("FAIL wdog_pre_sw got=%b exp=%b", {obs(), wdog_fired}, 6'b111000);
    end
    hold_cycles = 8'd0;
    sw_rst_req  = 1'b1;
    adv(35);
    sw_rst_req = 1'b0;
    n_cmp++;
    if ({obs(), wdog_fired} !== 6'b000110) begin
      n_bad++;
      $display("FAIL wdog_sw_wins got=%b exp=%b", {obs(), wdog_fired}, 6'b000110);
    end
    adv(68);
    kick = 1'b1;
    adv(69);
    kick = 1'b0;
    adv(70);
    n_cmp++;
    if ({obs(), wdog_fired} !== 6'b111000) begin
      n_bad++;
      $display("FAIL wdog_kick_wins got=%b exp=%b", {obs(), wdog_fired}, 6'b111000);
    end
    adv(88);
    n_cmp++;
    if ({obs(), wdog_fired} !== 6'b111000) begin
      n_bad++;
      $display("FAIL wdog_pre_fire got=%b exp=%b", {obs(), wdog_fired}, 6'b111000);
    end
    adv(89);
    n_cmp++;
    if ({obs(), wdog_fired} !== 6'b000101) begin
      n_bad++;
      $display("FAIL wdog_fire got=%b exp=%b", {obs(), wdog_fired}, 6'b000101);
    end
    adv(97);
    n_cmp++;
    if ({obs(), wdog_fired} !== 6'b001101) begin
      n_bad++;
      $display("FAIL wdog_clk_en got=%b exp=%b", {obs(), wdog_fired}, 6'b001101);
    end
    kick = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_power_on(1'b0);
    test_sw_reset();
    test_hold_zero();
    test_req_held();
    test_power_on(1'b1);
    test_mid_reset();
    test_l0_s0();
`ifdef UVMT_APB_ST_RST_SEQ_WDOG_EN
    test_watchdog();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout edge=%0d", cur_edge);
    $fatal(1, "bench timeout");
  end

endmodule
`default_nettype wire
